// File: rtl/parking_exit_manager_if.sv
// Exit-request handshake between the exit gate/billing logic (master) and
// parking_exit_manager (slave).
interface parking_exit_manager_if;
  logic       exit_req;
  logic [2:0] exit_spot;
  logic       exit_ready;
  logic       exit_done;
  logic [7:0] exit_fee;
  logic       exit_err;

  modport master (
    output exit_req,
    output exit_spot,
    input  exit_ready,
    input  exit_done,
    input  exit_fee,
    input  exit_err
  );

  modport slave (
    input  exit_req,
    input  exit_spot,
    output exit_ready,
    output exit_done,
    output exit_fee,
    output exit_err
  );
endinterface

// File: rtl/parking_exit_manager.sv
// Departure side of the 8-spot lot: occupancy map, per-spot saturating duration
// timers and a three-state exit FSM that computes the fee and frees the spot.
module parking_exit_manager #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned RATE     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   park_location,
  parking_exit_manager_if.slave        exit_bus,
  output logic [7:0]                   occupancy,
  output logic [3:0]                   free_count
);

  localparam int unsigned PresW = $clog2(TICK_DIV);
  localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StLookup, StRelease} state_e;

  state_e           state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [7:0]       occ_q, occ_d;
  logic [7:0]       timer_q [8];
  logic [7:0]       timer_d [8];
  logic [2:0]       spot_q, spot_d;
  logic [7:0]       fee_pend_q, fee_pend_d;
  logic             err_pend_q, err_pend_d;
  logic             done_q, done_d;
  logic [7:0]       fee_q, fee_d;
  logic             err_q, err_d;

  logic             tick;
  logic             release_spot;
  logic [15:0]      fee_raw;
  logic [7:0]       fee_sat;

  assign tick    = (presc_q == PresMax);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Fee is formed from the timer as it stands during LOOKUP, at 16 bits, then saturated.
  assign fee_raw = 16'(timer_q[spot_q]) * 16'(RATE);
  assign fee_sat = (fee_raw > 16'd255) ? 8'hFF : fee_raw[7:0];

  always_comb begin
    state_d      = state_q;
    spot_d       = spot_q;
    fee_pend_d   = fee_pend_q;
    err_pend_d   = err_pend_q;
    done_d       = 1'b0;
    fee_d        = fee_q;
    err_d        = err_q;
    release_spot = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (exit_bus.exit_req) begin
          spot_d  = exit_bus.exit_spot;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (occ_q[spot_q]) begin
          fee_pend_d = fee_sat;
          err_pend_d = 1'b0;
        end else begin
          fee_pend_d = 8'h00;
          err_pend_d = 1'b1;
        end
        state_d = StRelease;
      end
      StRelease: begin
        done_d       = 1'b1;
        fee_d        = fee_pend_q;
        err_d        = err_pend_q;
        release_spot = ~err_pend_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Order matters: tick, then release, then arrival so an arrival on a spot
  // being released wins with a fresh timer.
  always_comb begin
    occ_d = occ_q;
    for (int i = 0; i < 8; i++) begin
      timer_d[i] = timer_q[i];
      if (tick && occ_q[i] && (timer_q[i] != 8'hFF)) begin
        timer_d[i] = timer_q[i] + 8'd1;
      end
      if (release_spot && (spot_q == 3'(i))) begin
        occ_d[i]   = 1'b0;
        timer_d[i] = 8'h00;
      end
      if (park_location[i] && !occ_d[i]) begin
        occ_d[i]   = 1'b1;
        timer_d[i] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      occ_q      <= 8'h00;
      spot_q     <= 3'd0;
      fee_pend_q <= 8'h00;
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      fee_q      <= 8'h00;
      err_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        timer_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      occ_q      <= occ_d;
      spot_q     <= spot_d;
      fee_pend_q <= fee_pend_d;
      err_pend_q <= err_pend_d;
      done_q     <= done_d;
      fee_q      <= fee_d;
      err_q      <= err_d;
      for (int i = 0; i < 8; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  always_comb begin
    free_count = 4'd8;
    for (int i = 0; i < 8; i++) begin
      free_count = free_count - 4'(occ_q[i]);
    end
  end

  assign occupancy           = occ_q;
  assign exit_bus.exit_ready = (state_q == StIdle);
  assign exit_bus.exit_done  = done_q;
  assign exit_bus.exit_fee   = fee_q;
  assign exit_bus.exit_err   = err_q;

endmodule

// File: tb/tb_parking_exit_manager.sv
// Directed bench for parking_exit_manager: fees, saturation, empty-spot errors,
// arrival/release collisions, back-to-back exits and mid-transaction reset.
module tb_parking_exit_manager;

  logic       clk;
  logic       rst_n;
  logic [7:0] park_location;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  int         checks;
  int         failures;
  int         edge_cnt;
  int         a;
  int         exp_fee;

  parking_exit_manager_if bus ();

  parking_exit_manager #(
    .TICK_DIV (4),
    .RATE     (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .park_location (park_location),
    .exit_bus      (bus),
    .occupancy     (occupancy),
    .free_count    (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the prescaler ticks on every 4th one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with the FSM idle; request accepted on the next edge.
  task automatic run_exit(input string tag, input logic [2:0] spot, input logic [7:0] fee,
                          input logic err, input logic [7:0] occ);
    check({tag, ".ready_before"}, 32'(bus.exit_ready), 32'd1);
    bus.exit_req  = 1'b1;
    bus.exit_spot = spot;
    @(negedge clk);
    bus.exit_req = 1'b0;
    check({tag, ".ready_k"}, 32'(bus.exit_ready), 32'd0);
    check({tag, ".done_k"}, 32'(bus.exit_done), 32'd0);
    @(negedge clk);
    check({tag, ".ready_k1"}, 32'(bus.exit_ready), 32'd0);
    check({tag, ".done_k1"}, 32'(bus.exit_done), 32'd0);
    @(negedge clk);
    check({tag, ".done"}, 32'(bus.exit_done), 32'd1);
    check({tag, ".fee"}, 32'(bus.exit_fee), 32'(fee));
    check({tag, ".err"}, 32'(bus.exit_err), 32'(err));
    check({tag, ".occ"}, 32'(occupancy), 32'(occ));
    check({tag, ".free"}, 32'(free_count), 32'(8 - $countones(occ)));
    check({tag, ".ready_after"}, 32'(bus.exit_ready), 32'd1);
    @(negedge clk);
    check({tag, ".done_clear"}, 32'(bus.exit_done), 32'd0);
    check({tag, ".fee_hold"}, 32'(bus.exit_fee), 32'(fee));
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    park_location = 8'h00;
    bus.exit_req  = 1'b0;
    bus.exit_spot = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(bus.exit_ready), 32'd1);
    check("rst.occ", 32'(occupancy), 32'h00);
    check("rst.free", 32'(free_count), 32'd8);
    check("rst.done", 32'(bus.exit_done), 32'd0);
    check("rst.fee", 32'(bus.exit_fee), 32'd0);
    check("rst.err", 32'(bus.exit_err), 32'd0);
    rst_n = 1'b1;

    // Basic fee: 40 edges from arrival to acceptance = 10 ticks, fee 30
    park_location = 8'h04;
    @(negedge clk);
    park_location = 8'h00;
    check("basic.occ_arrive", 32'(occupancy), 32'h04);
    check("basic.free_arrive", 32'(free_count), 32'd7);
    repeat (39) @(negedge clk);
    run_exit("basic", 3'd2, 8'd30, 1'b0, 8'h00);

    // Fee saturation: 100 ticks (300 -> 255), then 300 ticks (timer pinned at 255)
    park_location = 8'h20;
    @(negedge clk);
    park_location = 8'h00;
    repeat (399) @(negedge clk);
    run_exit("sat100", 3'd5, 8'hFF, 1'b0, 8'h00);
    park_location = 8'h20;
    @(negedge clk);
    park_location = 8'h00;
    repeat (1199) @(negedge clk);
    run_exit("sat300", 3'd5, 8'hFF, 1'b0, 8'h00);

    // Empty spot
    park_location = 8'h01;
    @(negedge clk);
    park_location = 8'h00;
    check("empty.occ_arrive", 32'(occupancy), 32'h01);
    @(negedge clk);
    run_exit("empty", 3'd7, 8'h00, 1'b1, 8'h01);

    // Collision: spot 1 re-arrives on its own RELEASE edge; 2 ticks before acceptance
    park_location = 8'h02;
    @(negedge clk);
    park_location = 8'h00;
    repeat (7) @(negedge clk);
    bus.exit_req  = 1'b1;
    bus.exit_spot = 3'd1;
    @(negedge clk);
    bus.exit_req = 1'b0;
    @(negedge clk);
    park_location = 8'h02;
    @(negedge clk);
    park_location = 8'h00;
    check("coll.done", 32'(bus.exit_done), 32'd1);
    check("coll.fee", 32'(bus.exit_fee), 32'd6);
    check("coll.err", 32'(bus.exit_err), 32'd0);
    check("coll.occ", 32'(occupancy), 32'h03);
    // Fresh timer: exactly one tick in the next 4 edges
    repeat (3) @(negedge clk);
    run_exit("coll_timer", 3'd1, 8'd3, 1'b0, 8'h01);

    // Reset during LOOKUP
    bus.exit_req  = 1'b1;
    bus.exit_spot = 3'd0;
    @(negedge clk);
    bus.exit_req = 1'b0;
    check("rstmid.in_lookup", 32'(bus.exit_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.ready", 32'(bus.exit_ready), 32'd1);
    check("rstmid.occ", 32'(occupancy), 32'h00);
    check("rstmid.free", 32'(free_count), 32'd8);
    check("rstmid.done", 32'(bus.exit_done), 32'd0);
    check("rstmid.fee", 32'(bus.exit_fee), 32'd0);
    check("rstmid.err", 32'(bus.exit_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid.no_done", 32'(bus.exit_done), 32'd0);
    check("rstmid.occ_after", 32'(occupancy), 32'h00);

    // Back-to-back: spots 0 then 3, request held
    park_location = 8'h09;
    @(negedge clk);
    park_location = 8'h00;
    a = edge_cnt;
    check("b2b.occ_arrive", 32'(occupancy), 32'h09);
    repeat (7) @(negedge clk);
    bus.exit_req  = 1'b1;
    bus.exit_spot = 3'd0;
    @(negedge clk);
    bus.exit_spot = 3'd3;
    check("b2b.ready_k", 32'(bus.exit_ready), 32'd0);
    @(negedge clk);
    check("b2b.done_k1", 32'(bus.exit_done), 32'd0);
    @(negedge clk);
    check("b2b.done1", 32'(bus.exit_done), 32'd1);
    check("b2b.fee1", 32'(bus.exit_fee), 32'd6);
    check("b2b.occ1", 32'(occupancy), 32'h08);
    @(negedge clk);
    bus.exit_req = 1'b0;
    check("b2b.done_k3", 32'(bus.exit_done), 32'd0);
    check("b2b.ready_k3", 32'(bus.exit_ready), 32'd0);
    @(negedge clk);
    check("b2b.done_k4", 32'(bus.exit_done), 32'd0);
    @(negedge clk);
    exp_fee = 3 * ((a + 11) / 4 - a / 4);
    check("b2b.done2", 32'(bus.exit_done), 32'd1);
    check("b2b.fee2", 32'(bus.exit_fee), 32'(exp_fee));
    check("b2b.occ2", 32'(occupancy), 32'h00);
    check("b2b.free2", 32'(free_count), 32'd8);

    // All-spots arrival leaves occupied timers untouched
    @(negedge clk);
    park_location = 8'h09;
    @(negedge clk);
    park_location = 8'h00;
    repeat (3) @(negedge clk);
    park_location = 8'hFF;
    @(negedge clk);
    park_location = 8'h00;
    check("ff.occ", 32'(occupancy), 32'hFF);
    check("ff.free", 32'(free_count), 32'd0);
    repeat (3) @(negedge clk);
    run_exit("ff_exit", 3'd3, 8'd6, 1'b0, 8'hF7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
